// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
//   N_IRQ_DEF    : default number of request lines (matches the datapath intr width)
//   MASK_RST_DEF : default reset value of the mask register (all lines masked)
//   state_e      : handshake FSM states (IDLE / REQ / SERVICE)
package intr_ctrl_pkg;

  localparam int N_IRQ_DEF = 8;
  localparam logic [N_IRQ_DEF-1:0] MASK_RST_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Combinational fixed-priority encoder, bit 0 highest priority.
// Ports:
//   req : N-bit request vector
//   gnt : one-hot vector selecting the lowest set bit of req (0 when req == 0)
//   any : high when at least one request bit is set
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/intr_ctrl.sv
// Single-level interrupt controller between peripheral request lines and the
// CPU control unit / datapath vector decoder.
//   - Rising edges on irq set pending bits; mask gates eligibility only.
//   - Lowest-numbered eligible line is granted and held until end of interrupt.
//   - Handshake with the control unit: irq_req -> intr_ack -> intr_eoi.
// Optional build macro:
//   INTR_SYNC_EN : irq passes a 2-flop synchronizer before edge detection
//                  (request-to-irq_req latency 4 clocks instead of 2).
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   irq        : peripheral request lines, rising-edge sensitive
//   mask_we    : mask register write strobe
//   mask_in    : new mask value (1 = line masked)
//   intr_ack   : control unit took the vector (pulse, honoured only in REQ)
//   intr_eoi   : control unit returned from interrupt (pulse, honoured only in SERVICE)
//   irq_req    : interrupt request to the control unit (state REQ)
//   intr       : one-hot granted line during REQ and SERVICE, else 0
//   in_service : handler running (state SERVICE)
//   pending    : pending register readback
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int               N_IRQ    = N_IRQ_DEF,
  parameter logic [N_IRQ-1:0] MASK_RST = {N_IRQ{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             intr_ack,
  input  logic             intr_eoi,
  output logic             irq_req,
  output logic [N_IRQ-1:0] intr,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_clr;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] pe_gnt;
  logic             pe_any;
  logic [N_IRQ-1:0] gnt_q;
  logic             gnt_ld;
  state_e           state_q;
  state_e           state_d;

  // ---- stage p0: optional input synchronizer ----
`ifdef INTR_SYNC_EN
  logic [N_IRQ-1:0] irq_p0;
  logic [N_IRQ-1:0] irq_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_p0 <= '0;
      irq_p1 <= '0;
    end else begin
      irq_p0 <= irq;
      irq_p1 <= irq_p0;
    end
  end

  assign irq_s = irq_p1;
`else
  assign irq_s = irq;
`endif

  // ---- stage p1: edge detect, mask and pending registers ----
  assign rise = irq_s & ~irq_prev;

  // Only the granted line is cleared, and only when the ack is honoured.
  assign pending_clr = (state_q == ST_REQ && intr_ack) ? gnt_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev  <= '0;
      mask_q    <= MASK_RST;
      pending_q <= '0;
    end else begin
      irq_prev <= irq_s;
      if (mask_we) begin
        mask_q <= mask_in;
      end
      // OR-ing rise after the clear lets a fresh edge survive a same-cycle ack.
      pending_q <= (pending_q & ~pending_clr) | rise;
    end
  end

  assign eligible = pending_q & ~mask_q;

  prio_enc #(
    .N (N_IRQ)
  ) u_prio_enc (
    .req (eligible),
    .gnt (pe_gnt),
    .any (pe_any)
  );

  // ---- stage p2: handshake FSM and grant register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_ld) begin
        gnt_q <= pe_gnt;
      end
    end
  end

  // Grant is captured only when leaving IDLE, so neither mask writes nor new
  // higher-priority edges can disturb an active request or handler.
  always_comb begin
    state_d = state_q;
    gnt_ld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pe_any) begin
          state_d = ST_REQ;
          gnt_ld  = 1'b1;
        end
      end
      ST_REQ: begin
        if (intr_ack) begin
          state_d = ST_SERV;
        end
      end
      ST_SERV: begin
        if (intr_eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign irq_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERV);
  assign intr       = (state_q == ST_REQ || state_q == ST_SERV) ? gnt_q : '0;
  assign pending    = pending_q;

endmodule
